// File: rtl/pc_gen_if.sv
// ---------------------------------------------------------------------------
// pc_gen_if : fetch-PC generator bus.
//   Groups the PCSel code, the candidate next-PC addresses, the IF-side
//   ready, and the fetch PC handed to IF with its status flags.
//   master : upstream/IF side (drives PCSel, candidates, IF_Ready).
//   slave  : pc_gen side (drives PC_Out, PC_Valid, PC_Kill, PC_AdEL,
//            Redirect_Pending).
// ---------------------------------------------------------------------------
interface pc_gen_if #(
  parameter int unsigned PCSEL_W = 3
);
  localparam int unsigned ADDR_W = 32;

  logic [PCSEL_W-1:0] PCSel;
  logic [ADDR_W-1:0]  BPU_Target;
  logic [ADDR_W-1:0]  Correct_PC;
  logic [ADDR_W-1:0]  EPC;
  logic [ADDR_W-1:0]  MEM_PC;
  logic [ADDR_W-1:0]  Except_PC;
  logic               IF_Ready;

  logic [ADDR_W-1:0]  PC_Out;
  logic               PC_Valid;
  logic               PC_Kill;
  logic               PC_AdEL;
  logic               Redirect_Pending;

  modport master (
    output PCSel, BPU_Target, Correct_PC, EPC, MEM_PC, Except_PC, IF_Ready,
    input  PC_Out, PC_Valid, PC_Kill, PC_AdEL, Redirect_Pending
  );

  modport slave (
    input  PCSel, BPU_Target, Correct_PC, EPC, MEM_PC, Except_PC, IF_Ready,
    output PC_Out, PC_Valid, PC_Kill, PC_AdEL, Redirect_Pending
  );
endinterface

// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen : pre-IF program-counter register and next-PC mux.
//   Holds the architectural fetch PC and offers it to IF over a valid/ready
//   handshake. Redirects (Correct/EPC/MEMPC/Except) that arrive while IF is
//   stalled are buffered in a single pending slot (newest wins), so the
//   presented PC stays stable until IF accepts it and no redirect is lost.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : pc_gen_if.slave
//          in : PCSel, BPU_Target, Correct_PC, EPC, MEM_PC, Except_PC,
//               IF_Ready
//          out: PC_Out (registered), PC_Valid (registered),
//               PC_Kill (comb, only set on fire), PC_AdEL (comb from PC_Out),
//               Redirect_Pending (state == HOLD)
// ---------------------------------------------------------------------------
module pc_gen #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int unsigned PCSEL_W  = 3
) (
  input  logic     clk,
  input  logic     rst,
  pc_gen_if.slave  bus
);

  localparam int unsigned ADDR_W = 32;

  localparam logic [PCSEL_W-1:0] SEL_PC4     = PCSEL_W'(0);
  localparam logic [PCSEL_W-1:0] SEL_TARGET  = PCSEL_W'(1);
  localparam logic [PCSEL_W-1:0] SEL_CORRECT = PCSEL_W'(2);
  localparam logic [PCSEL_W-1:0] SEL_EPC     = PCSEL_W'(3);
  localparam logic [PCSEL_W-1:0] SEL_MEMPC   = PCSEL_W'(4);
  localparam logic [PCSEL_W-1:0] SEL_EXCEPT  = PCSEL_W'(5);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_pend_pc;
  logic                r_valid;

  logic                w_fire;
  logic                w_redir;
  logic [ADDR_W-1:0]   w_redir_pc;
  logic [ADDR_W-1:0]   w_seq_pc;
  logic [ADDR_W-1:0]   w_pc_nxt;
  logic [ADDR_W-1:0]   w_pend_nxt;
  logic                w_kill;

  assign w_fire = r_valid & bus.IF_Ready;

  // Redirect-class decode; codes 6-7 fall into the sequential (PC4) class.
  always_comb begin
    w_redir    = 1'b0;
    w_redir_pc = '0;
    case (bus.PCSel)
      SEL_CORRECT: begin w_redir = 1'b1; w_redir_pc = bus.Correct_PC; end
      SEL_EPC:     begin w_redir = 1'b1; w_redir_pc = bus.EPC;        end
      SEL_MEMPC:   begin w_redir = 1'b1; w_redir_pc = bus.MEM_PC;     end
      SEL_EXCEPT:  begin w_redir = 1'b1; w_redir_pc = bus.Except_PC;  end
      default:     begin w_redir = 1'b0; w_redir_pc = '0;             end
    endcase
  end

  // Sequential-class next PC; PC + 4 wraps modulo 2^32.
  assign w_seq_pc = (bus.PCSel == SEL_TARGET) ? bus.BPU_Target
                                              : r_pc + ADDR_W'(4);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  // Next-state: enter HOLD on a stalled redirect, leave it on the next fire.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:  if (w_redir && !w_fire) w_state_nxt = ST_HOLD;
      ST_HOLD: if (w_fire)             w_state_nxt = ST_RUN;
      default:                         w_state_nxt = ST_RUN;
    endcase
  end

  // Datapath decisions: next PC, pending slot update, and the kill flag.
  always_comb begin
    w_pc_nxt   = r_pc;
    w_pend_nxt = r_pend_pc;
    w_kill     = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_fire) begin
          if (w_redir) begin
            w_pc_nxt = w_redir_pc;
            w_kill   = 1'b1;
          end else begin
            w_pc_nxt = w_seq_pc;
          end
        end else if (w_redir) begin
          w_pend_nxt = w_redir_pc;
        end
      end
      ST_HOLD: begin
        // Sequential candidates are ignored here; a fresh redirect overrides
        // the buffered one.
        if (w_fire) begin
          w_kill   = 1'b1;
          w_pc_nxt = w_redir ? w_redir_pc : r_pend_pc;
        end else if (w_redir) begin
          w_pend_nxt = w_redir_pc;
        end
      end
      default: begin
        w_pc_nxt   = r_pc;
        w_pend_nxt = r_pend_pc;
        w_kill     = 1'b0;
      end
    endcase
  end

  // PC, pending slot and valid registers. Valid rises one cycle after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_pend_pc <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_pc      <= w_pc_nxt;
      r_pend_pc <= w_pend_nxt;
      r_valid   <= 1'b1;
    end
  end

  assign bus.PC_Out           = r_pc;
  assign bus.PC_Valid         = r_valid;
  assign bus.PC_Kill          = w_kill;
  assign bus.PC_AdEL          = |r_pc[1:0];
  assign bus.Redirect_Pending = (r_state == ST_HOLD);

endmodule

// File: tb/tb_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_pc_gen : directed + randomized bench for pc_gen with a scoreboard.
// ---------------------------------------------------------------------------
module tb_pc_gen;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pc_gen_if #(.PCSEL_W(3)) bus ();

  pc_gen #(.RESET_PC(RST_PC), .PCSEL_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic        v;
    logic        p;
    logic [31:0] pc;
    logic        k;
  } cyc_t;

  typedef struct {
    logic [31:0] pc;
    logic        k;
  } txn_t;

  cyc_t cyc_q[$];
  txn_t txn_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  bit   mon_en = 1'b0;

  // Reference model: current fetch PC, valid flag, and an optional buffered
  // redirect (queue holding at most one address).
  logic [31:0] m_pc;
  bit          m_valid;
  logic [31:0] m_pend[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input int act, input int exp);
    n_cmp++;
    n_mis++;
    $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic void model_reset();
    m_pc    = RST_PC;
    m_valid = 1'b0;
    m_pend.delete();
  endfunction

  // One clock cycle: drive inputs at posedge+1, log expectations, advance model.
  task automatic cycle(input logic [2:0] sel, input logic [31:0] tgt,
                       input logic [31:0] cor, input logic [31:0] epc,
                       input logic [31:0] mem, input logic [31:0] exc,
                       input logic rdy);
    bit          redir;
    bit          fire;
    bit          kill;
    logic [31:0] rpc;
    logic [31:0] nxt;
    cyc_t        c;
    txn_t        t;
    bus.PCSel      = sel;
    bus.BPU_Target = tgt;
    bus.Correct_PC = cor;
    bus.EPC        = epc;
    bus.MEM_PC     = mem;
    bus.Except_PC  = exc;
    bus.IF_Ready   = rdy;
    redir = 1'b1;
    case (sel)
      3'd2:    rpc = cor;
      3'd3:    rpc = epc;
      3'd4:    rpc = mem;
      3'd5:    rpc = exc;
      default: begin redir = 1'b0; rpc = '0; end
    endcase
    fire = m_valid && rdy;
    kill = 1'b0;
    nxt  = m_pc;
    c.v  = m_valid;
    c.p  = (m_pend.size() > 0);
    c.pc = m_pc;
    if (fire) begin
      if (redir) begin
        kill = 1'b1;
        nxt  = rpc;
      end else if (m_pend.size() > 0) begin
        kill = 1'b1;
        nxt  = m_pend[0];
      end else if (sel == 3'd1) begin
        nxt = tgt;
      end else begin
        nxt = m_pc + 32'd4;
      end
      m_pend.delete();
    end else if (redir) begin
      m_pend.delete();
      m_pend.push_back(rpc);
    end
    c.k = kill;
    cyc_q.push_back(c);
    if (fire) begin
      t.pc = m_pc;
      t.k  = kill;
      txn_q.push_back(t);
    end
    m_pc    = nxt;
    m_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  // Monitor: per-cycle state check plus a pop of the transaction scoreboard
  // whenever the DUT shows a handshake.
  cyc_t mc;
  txn_t mt;
  always @(negedge clk) begin
    if (mon_en) begin
      if (cyc_q.size() == 0) begin
        fail("cyc_underrun", 0, 1);
      end else begin
        mc = cyc_q.pop_front();
        chk("PC_Valid", 32'(bus.PC_Valid), 32'(mc.v));
        chk("Redirect_Pending", 32'(bus.Redirect_Pending), 32'(mc.p));
        chk("PC_Out", bus.PC_Out, mc.pc);
        chk("PC_Kill", 32'(bus.PC_Kill), 32'(mc.k));
        chk("PC_AdEL", 32'(bus.PC_AdEL), 32'(mc.pc[1:0] != 2'b00));
      end
      if (bus.PC_Valid && bus.IF_Ready) begin
        if (txn_q.size() == 0) begin
          fail("unexpected_fire", 1, 0);
        end else begin
          mt = txn_q.pop_front();
          chk("fire_pc", bus.PC_Out, mt.pc);
          chk("fire_kill", 32'(bus.PC_Kill), 32'(mt.k));
        end
      end
    end
  end

  initial begin
    rst            = 1'b1;
    bus.PCSel      = 3'd0;
    bus.BPU_Target = '0;
    bus.Correct_PC = '0;
    bus.EPC        = '0;
    bus.MEM_PC     = '0;
    bus.Except_PC  = '0;
    bus.IF_Ready   = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc", bus.PC_Out, RST_PC);
    chk("rst_valid", 32'(bus.PC_Valid), 32'd0);
    chk("rst_kill", 32'(bus.PC_Kill), 32'd0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Reset release, sequential fetch.
    chk("t1_valid0", 32'(bus.PC_Valid), 32'd0);
    chk("t1_pc0", bus.PC_Out, 32'hBFC0_0000);
    repeat (3) cycle(3'd0, '0, '0, '0, '0, '0, 1'b1);
    chk("t1_pc_seq", bus.PC_Out, 32'hBFC0_0008);

    // Predicted target, then stall with target held off.
    cycle(3'd2, '0, 32'hBFC0_0010, '0, '0, '0, 1'b1);
    repeat (3) cycle(3'd1, 32'hBFC0_0100, '0, '0, '0, '0, 1'b0);
    chk("t2_stall_pc", bus.PC_Out, 32'hBFC0_0010);
    cycle(3'd1, 32'hBFC0_0100, '0, '0, '0, '0, 1'b1);
    chk("t2_target", bus.PC_Out, 32'hBFC0_0100);

    // Redirect during stall is buffered, then released with kill.
    cycle(3'd2, '0, 32'h8000_0040, '0, '0, '0, 1'b0);
    repeat (2) cycle(3'd0, '0, '0, '0, '0, '0, 1'b0);
    chk("t3_pending", 32'(bus.Redirect_Pending), 32'd1);
    chk("t3_hold_pc", bus.PC_Out, 32'hBFC0_0100);
    cycle(3'd0, '0, '0, '0, '0, '0, 1'b1);
    chk("t3_redir_pc", bus.PC_Out, 32'h8000_0040);
    chk("t3_pending_clr", 32'(bus.Redirect_Pending), 32'd0);

    // Newest redirect supersedes the buffered one.
    cycle(3'd2, '0, 32'h8000_0040, '0, '0, '0, 1'b0);
    cycle(3'd5, '0, '0, '0, '0, 32'hBFC0_0380, 1'b0);
    cycle(3'd0, '0, '0, '0, '0, '0, 1'b1);
    chk("t4_newest", bus.PC_Out, 32'hBFC0_0380);

    // Misaligned EPC and PC+4 wrap.
    cycle(3'd3, '0, '0, 32'h8000_0102, '0, '0, 1'b1);
    chk("t5_epc", bus.PC_Out, 32'h8000_0102);
    chk("t5_adel", 32'(bus.PC_AdEL), 32'd1);
    cycle(3'd4, '0, '0, '0, 32'hFFFF_FFFC, '0, 1'b1);
    cycle(3'd0, '0, '0, '0, '0, '0, 1'b1);
    chk("t5_wrap", bus.PC_Out, 32'h0000_0000);

    // Asynchronous reset in the middle of HOLD.
    cycle(3'd2, '0, 32'h1234_5678, '0, '0, '0, 1'b0);
    chk("t6_in_hold", 32'(bus.Redirect_Pending), 32'd1);
    mon_en = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("t6_async_pc", bus.PC_Out, RST_PC);
    chk("t6_async_valid", 32'(bus.PC_Valid), 32'd0);
    chk("t6_async_pend", 32'(bus.Redirect_Pending), 32'd0);
    cyc_q.delete();
    txn_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (3) cycle(3'd0, '0, '0, '0, '0, '0, 1'b1);
    chk("t6_resume", bus.PC_Out, 32'hBFC0_0008);
    chk("t6_no_stale", 32'(bus.Redirect_Pending), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cycle(3'($urandom_range(0, 7)), rnd_addr(), rnd_addr(), rnd_addr(),
            rnd_addr(), rnd_addr(), ($urandom_range(0, 9) < 7));
    end

    mon_en = 1'b0;
    chk("cyc_drain", 32'(cyc_q.size()), 32'd0);
    chk("txn_drain", 32'(txn_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
